// File: rtl/seq_det_multi.sv
// Serial pattern detector: PAT_W-bit history matched against one of two programmable patterns, with overlap control and a saturating match counter.
// flag is registered, one cycle after the completing bit's edge; no backpressure, one bit is accepted per in_vld beat.
module seq_det_multi #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic             in_bit,
    input  logic             sel,
    input  logic [PAT_W-1:0] pat0,
    input  logic [PAT_W-1:0] pat1,
    input  logic             overlap_en,
    input  logic             clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] sr, sr_nxt, sr_shift;
    logic [FW-1:0]    fill, fill_nxt, fill_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sel_q, flag_nxt, hit;

    always_comb begin
        sr_shift = {sr[PAT_W-2:0], in_bit};
        fill_inc = (fill == FULL) ? fill : fill + 1'b1;
        hit      = (fill_inc == FULL) && (sr_shift == (sel ? pat1 : pat0));

        sr_nxt   = sr;
        fill_nxt = fill;
        cnt_nxt  = match_cnt;
        flag_nxt = 1'b0;

        if (clr) begin
            sr_nxt   = '0;
            fill_nxt = '0;
            cnt_nxt  = '0;
        end else if (sel != sel_q) begin
            // Pattern switch: history must refill with bits meant for the new pattern.
            fill_nxt = '0;
        end else if (in_vld) begin
            sr_nxt   = sr_shift;
            flag_nxt = hit;
            fill_nxt = fill_inc;
            if (hit) begin
                if (!(&match_cnt)) cnt_nxt = match_cnt + 1'b1;
                if (!overlap_en) fill_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            fill      <= '0;
            sel_q     <= 1'b0;
            flag      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            sr        <= sr_nxt;
            fill      <= fill_nxt;
            sel_q     <= sel;
            flag      <= flag_nxt;
            match_cnt <= cnt_nxt;
            cnt_sat   <= &cnt_nxt;
        end
    end

endmodule
